// File: rtl/mux4_rr_sched_pkg.sv
// -----------------------------------------------------------------------------
// mux_sched_pkg
// Shared definitions for the round-robin 4:1 mux scheduler:
//   NUM_REQ      number of requesters sharing the mux datapath
//   IDLE/GRANT   scheduler state encoding
//   rr_pick()    cyclic priority search returning {found, idx[1:0]}
// -----------------------------------------------------------------------------
package mux_sched_pkg;

    localparam int NUM_REQ = 4;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    // Cyclic search starting at ptr: ptr, ptr+1, ... ptr+3 (mod 4). Lines set in
    // excl_mask are skipped. The loop walks the offsets from farthest to nearest
    // so the nearest eligible line overwrites any earlier hit and wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] ptr,
                                           input logic [3:0] excl_mask);
        logic [2:0] res;
        logic [1:0] idx;
        logic [3:0] elig;
        res  = '0;
        elig = req & ~excl_mask;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (elig[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux4_rr_sched_if.sv
// -----------------------------------------------------------------------------
// mux4_rr_sched_if
// Bundles the requester side of the scheduler: level requests, the four data
// inputs, and the grant / select / muxed-output results.
//   req        4      request per requester
//   I0..I3     WIDTH  requester data
//   gnt        4      one-hot grant (registered)
//   S1, S0     1      registered mux select
//   out        WIDTH  selected data
//   out_valid  1      a grant is active
// Modports: master = requester side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface mux4_rr_sched_if #(
    parameter int WIDTH = 1
);

    logic [3:0]       req;
    logic [WIDTH-1:0] I0;
    logic [WIDTH-1:0] I1;
    logic [WIDTH-1:0] I2;
    logic [WIDTH-1:0] I3;
    logic [3:0]       gnt;
    logic             S1;
    logic             S0;
    logic [WIDTH-1:0] out;
    logic             out_valid;

    modport master (
        output req, I0, I1, I2, I3,
        input  gnt, S1, S0, out, out_valid
    );

    modport slave (
        input  req, I0, I1, I2, I3,
        output gnt, S1, S0, out, out_valid
    );

endinterface

// File: rtl/mux4_rr_sched_datapath.sv
// -----------------------------------------------------------------------------
// mux4_1
// Structural single-bit 4:1 mux cell.
//   s1, s0      select (s1 is the MSB)
//   i0..i3      data inputs
//   y           selected input
// -----------------------------------------------------------------------------
module mux4_1 (
    input  logic s1,
    input  logic s0,
    input  logic i0,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    output logic y
);

    logic ns1;
    logic ns0;

    assign ns1 = ~s1;
    assign ns0 = ~s0;

    // Sum of products, one minterm per select code.
    assign y = (i0 & ns1 & ns0) |
               (i1 & ns1 &  s0) |
               (i2 &  s1 & ns0) |
               (i3 &  s1 &  s0);

endmodule

// -----------------------------------------------------------------------------
// mux4_rr_sched_datapath
// WIDTH bit-slices of mux4_1 sharing one select pair.
//   s1, s0      select from the scheduler
//   i0..i3      WIDTH-bit data inputs
//   y           WIDTH-bit selected data
// -----------------------------------------------------------------------------
module mux4_rr_sched_datapath #(
    parameter int WIDTH = 1
) (
    input  logic             s1,
    input  logic             s0,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic [WIDTH-1:0] y
);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
        mux4_1 u_mux (
            .s1 (s1),
            .s0 (s0),
            .i0 (i0[gi]),
            .i1 (i1[gi]),
            .i2 (i2[gi]),
            .i3 (i3[gi]),
            .y  (y[gi])
        );
    end

endmodule

// File: rtl/mux4_rr_sched.sv
// -----------------------------------------------------------------------------
// mux4_rr_sched
// Round-robin scheduler in front of a shared 4:1 mux datapath. Arbitrates the
// four level requests, registers a one-hot grant and the matching mux select,
// and limits each tenure to MAX_HOLD consecutive cycles.
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset
//   bus        mux4_rr_sched_if.slave: req, I0..I3 in; gnt, S1, S0, out,
//              out_valid out
// Parameters: WIDTH data width, MAX_HOLD tenure limit (>= 1).
// -----------------------------------------------------------------------------
module mux4_rr_sched
    import mux_sched_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mux4_rr_sched_if.slave       bus
);

    localparam int                HOLD_W     = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

    logic [0:0]        state_q, state_d;
    logic [1:0]        ptr_q,   ptr_d;
    logic [HOLD_W-1:0] hold_q,  hold_d;
    logic [3:0]        gnt_q,   gnt_d;
    logic [1:0]        sel_q,   sel_d;

    logic [2:0]        pick;
    logic [3:0]        own_mask;
    logic [1:0]        next_ptr;
    logic [WIDTH-1:0]  mux_y;

    // The granted index is the registered select; the search after a tenure
    // starts just past it and skips it, so a second requester always gets in
    // ahead of the line that just finished.
    assign own_mask = 4'b0001 << sel_q;
    assign next_ptr = sel_q + 2'd1;

    // Next-state logic. In GRANT the tenure ends either by release of the
    // granted line or by hitting the hold limit; both move the pointer past
    // the current owner. A forced rotate with nobody else waiting re-grants
    // the same line with a fresh count, which is why the request of the
    // current owner is re-examined when the excluded search comes back empty.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        pick    = '0;

        if (state_q == IDLE) begin
            pick = rr_pick(bus.req, ptr_q, 4'b0000);
            if (pick[2]) begin
                state_d = GRANT;
                sel_d   = pick[1:0];
                gnt_d   = 4'b0001 << pick[1:0];
                hold_d  = HOLD_ONE;
            end
        end else begin
            if (bus.req[sel_q] && (hold_q < HOLD_LIMIT)) begin
                hold_d = hold_q + HOLD_ONE;
            end else begin
                ptr_d = next_ptr;
                pick  = rr_pick(bus.req, next_ptr, own_mask);
                if (pick[2]) begin
                    sel_d  = pick[1:0];
                    gnt_d  = 4'b0001 << pick[1:0];
                    hold_d = HOLD_ONE;
                end else if (bus.req[sel_q]) begin
                    hold_d = HOLD_ONE;
                end else begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    hold_d  = '0;
                end
            end
        end
    end

    // State registers. Reset wins over everything, including an active
    // tenure, and puts the select back on input 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            hold_q  <= '0;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
        end
    end

    mux4_rr_sched_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .s1 (sel_q[1]),
        .s0 (sel_q[0]),
        .i0 (bus.I0),
        .i1 (bus.I1),
        .i2 (bus.I2),
        .i3 (bus.I3),
        .y  (mux_y)
    );

    assign bus.gnt       = gnt_q;
    assign bus.S1        = sel_q[1];
    assign bus.S0        = sel_q[0];
    assign bus.out       = mux_y;
    assign bus.out_valid = |gnt_q;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_mux4_rr_sched
// Directed bench for mux4_rr_sched. dut_a uses MAX_HOLD=8 for the single,
// back-to-back, lone-hog and mid-reset scenarios; dut_b uses MAX_HOLD=2 for
// the full rotation scenario. Both share clock and reset.
// -----------------------------------------------------------------------------
module tb_mux4_rr_sched;

    localparam int WIDTH = 4;

    logic clk;
    logic rst;

    int checks;
    int errors;

    mux4_rr_sched_if #(.WIDTH(WIDTH)) bus_a ();
    mux4_rr_sched_if #(.WIDTH(WIDTH)) bus_b ();

    mux4_rr_sched #(.WIDTH(WIDTH), .MAX_HOLD(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    mux4_rr_sched #(.WIDTH(WIDTH), .MAX_HOLD(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive reset and both request vectors, then advance one clock and settle
    // 1 time unit past the edge so outputs are sampled away from it.
    task automatic applyStimulus(input logic r, input logic [3:0] ra, input logic [3:0] rb);
        rst       = r;
        bus_a.req = ra;
        bus_b.req = rb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        bus_a.I0 = 4'h1; bus_a.I1 = 4'h6; bus_a.I2 = 4'hA; bus_a.I3 = 4'hD;
        bus_b.I0 = 4'h3; bus_b.I1 = 4'h5; bus_b.I2 = 4'h9; bus_b.I3 = 4'hC;
        rst       = 1'b1;
        bus_a.req = 4'hF;
        bus_b.req = 4'h0;

        // 1: reset held two clocks with all requests up.
        applyStimulus(1'b1, 4'hF, 4'h0);
        applyStimulus(1'b1, 4'hF, 4'h0);
        checkOutput("reset_gnt",   32'(bus_a.gnt), 32'h0);
        checkOutput("reset_sel",   32'({bus_a.S1, bus_a.S0}), 32'h0);
        checkOutput("reset_valid", 32'(bus_a.out_valid), 32'h0);
        checkOutput("reset_out",   32'(bus_a.out), 32'h1);
        checkOutput("reset_gnt_b", 32'(bus_b.gnt), 32'h0);

        // 2: single request from idle, then release.
        applyStimulus(1'b0, 4'b0100, 4'h0);
        checkOutput("single_gnt",   32'(bus_a.gnt), 32'h4);
        checkOutput("single_sel",   32'({bus_a.S1, bus_a.S0}), 32'h2);
        checkOutput("single_out",   32'(bus_a.out), 32'hA);
        checkOutput("single_valid", 32'(bus_a.out_valid), 32'h1);
        checkOutput("single_hold",  32'(dut_a.hold_q), 32'h1);
        applyStimulus(1'b0, 4'b0000, 4'h0);
        checkOutput("drop_gnt",   32'(bus_a.gnt), 32'h0);
        checkOutput("drop_valid", 32'(bus_a.out_valid), 32'h0);
        checkOutput("drop_sel",   32'({bus_a.S1, bus_a.S0}), 32'h2);

        // 4: back-to-back. Pointer is 3 after the release, so 0011 picks 0.
        applyStimulus(1'b0, 4'b0011, 4'h0);
        checkOutput("b2b_first_gnt", 32'(bus_a.gnt), 32'h1);
        checkOutput("b2b_first_out", 32'(bus_a.out), 32'h1);
        applyStimulus(1'b0, 4'b0010, 4'h0);
        checkOutput("b2b_next_gnt",   32'(bus_a.gnt), 32'h2);
        checkOutput("b2b_next_valid", 32'(bus_a.out_valid), 32'h1);
        checkOutput("b2b_next_out",   32'(bus_a.out), 32'h6);
        checkOutput("b2b_next_hold",  32'(dut_a.hold_q), 32'h1);
        applyStimulus(1'b0, 4'b0000, 4'h0);
        checkOutput("b2b_idle_gnt", 32'(bus_a.gnt), 32'h0);

        // 5: lone hog on line 1 for 20 clocks; count wraps 1..8 and re-grants.
        for (int n = 1; n <= 20; n++) begin
            applyStimulus(1'b0, 4'b0010, 4'h0);
            checkOutput($sformatf("hog_gnt_%0d", n),  32'(bus_a.gnt), 32'h2);
            checkOutput($sformatf("hog_hold_%0d", n), 32'(dut_a.hold_q), 32'(((n - 1) % 8) + 1));
        end
        applyStimulus(1'b0, 4'b0000, 4'h0);
        checkOutput("hog_idle_gnt", 32'(bus_a.gnt), 32'h0);

        // 6: mid-tenure reset. Pointer is 2, so 1000 grants line 3 first.
        applyStimulus(1'b0, 4'b1000, 4'h0);
        checkOutput("midrst_pre_gnt", 32'(bus_a.gnt), 32'h8);
        applyStimulus(1'b0, 4'b1000, 4'h0);
        checkOutput("midrst_pre_hold", 32'(dut_a.hold_q), 32'h2);
        applyStimulus(1'b1, 4'b1001, 4'h0);
        checkOutput("midrst_gnt",   32'(bus_a.gnt), 32'h0);
        checkOutput("midrst_sel",   32'({bus_a.S1, bus_a.S0}), 32'h0);
        checkOutput("midrst_valid", 32'(bus_a.out_valid), 32'h0);
        applyStimulus(1'b0, 4'b1001, 4'h0);
        checkOutput("midrst_regnt", 32'(bus_a.gnt), 32'h1);
        checkOutput("midrst_out",   32'(bus_a.out), 32'h1);

        // 3: rotation on dut_b, MAX_HOLD=2, all requests up: 0,0,1,1,2,2,3,3,0,0.
        for (int n = 1; n <= 10; n++) begin
            logic [1:0] k;
            k = 2'(((n - 1) / 2) % 4);
            applyStimulus(1'b0, 4'b0000, 4'hF);
            checkOutput($sformatf("rot_gnt_%0d", n), 32'(bus_b.gnt), 32'(4'b0001 << k));
            checkOutput($sformatf("rot_sel_%0d", n), 32'({bus_b.S1, bus_b.S0}), 32'(k));
        end
        // Drop the current owner (line 0, second cycle just done) mid-rotation:
        // after n=10 the owner is 0 at its limit; rotate moves to 1 regardless.
        applyStimulus(1'b0, 4'b0000, 4'b1110);
        checkOutput("rot_after_gnt", 32'(bus_b.gnt), 32'h2);
        checkOutput("rot_after_out", 32'(bus_b.out), 32'h5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
